mc_control_fsm: RTL and testbench

- Multicycle MIPS control unit; it is the controlling end of the ALU interface.
- Decodes the opcode and funct fields of the held instruction and sequences the datapath through fetch, decode, execute, memory and writeback.
- Drives the 3-bit ALU control code and datapath selects/enables, and consumes the ALU Zero flag for branches.
- Sits between the instruction register and the datapath muxes, register file, memory and PC.

---
 rtl/mc_control_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Multicycle MIPS control unit. Decodes Op/Funct of the held instruction and
// sequences the datapath through fetch, decode, execute, memory and writeback,
// driving the ALU control code, datapath selects and write enables. The ALU
// Zero flag is consumed in the branch states.
//
// Ports:
//   clk      - system clock, rising-edge
//   reset    - synchronous active-high reset; state returns to FETCH
//   Op       - Instr[31:26]
//   Funct    - Instr[5:0]
//   Zero     - ALU zero flag (same cycle)
//   PCEn, IRWrite, MemWrite, RegWrite - write enables
//   IorD, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSrc - datapath selects
//   ALUCtl   - 3-bit ALU operation code
//   Illegal  - unsupported Op/Funct seen in DECODE
//   State    - current state encoding (debug)
//
// Optional feature: define MC_CTRL_BNE_EN to add bne support (state BNEBR=12).

module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUCtl,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_BNEBR  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;
  state_t out_state;
  logic   funct_ok;
  logic   op_illegal;
  logic [2:0] funct_alu;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // R-type funct decode: supported flag and the ALU code it selects
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (Funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Opcode legality as seen in DECODE
  always_comb begin
    op_illegal = 1'b0;
    case (Op)
      OP_RTYPE: op_illegal = ~funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_illegal = 1'b0;
`ifdef MC_CTRL_BNE_EN
      OP_BNE:   op_illegal = 1'b0;
`endif
      default:  op_illegal = 1'b1;
    endcase
  end

  // Next-state logic; unreachable codes fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_RTYPE: state_d = funct_ok ? S_EXEC : S_FETCH;
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_J:     state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:   state_d = S_BNEBR;
`endif
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // While reset is high the outputs decode as FETCH, with every write
  // enable masked so an aborted instruction cannot modify state.
  assign out_state = reset ? S_FETCH : state_q;

  // Moore output decode; anything not set for a state stays 0 (ALUCtl ADD)
  always_comb begin
    PCEn     = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    IorD     = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    ALUCtl   = 3'b010;
    Illegal  = 1'b0;
    case (out_state)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = 1'b1;
        PCEn    = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Illegal = op_illegal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:  IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUCtl  = funct_alu;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUCtl  = 3'b110;
        PCSrc   = 2'b01;
        PCEn    = Zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNEBR: begin
        ALUSrcA = 1'b1;
        ALUCtl  = 3'b110;
        PCSrc   = 2'b01;
        PCEn    = ~Zero;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign State = out_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
// Scoreboard bench for mc_control_fsm: each directed instruction pushes its
// per-cycle expected output vectors into a queue; a monitor on the falling
// clock edge pops and compares one vector per cycle.

module tb_mc_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen;
    logic       irw;
    logic       memw;
    logic       regw;
    logic       iord;
    logic       m2r;
    logic       regdst;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic [2:0] alu;
    logic       ill;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCEn, IRWrite, MemWrite, RegWrite, IorD, MemtoReg, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUCtl;
  logic       Illegal;
  logic [3:0] State;

  exp_t  expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    passes = 0;

  mc_control_fsm dut (
    .clk(clock), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCEn(PCEn), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUCtl(ALUCtl), .Illegal(Illegal),
    .State(State)
  );

  // 10-unit clock
  always #5 clock = ~clock;

  // Expected outputs for a state, straight from the state table
  function automatic exp_t expOut(input int s, input logic [2:0] alu,
                                  input logic pcen, input logic ill);
    exp_t e;
    e = '0;
    e.st = s[3:0];
    e.alu = 3'b010;
    case (s)
      0:  begin e.srcb = 2'b01; e.irw = 1'b1; e.pcen = 1'b1; end
      1:  begin e.srcb = 2'b11; e.ill = ill; end
      2:  begin e.srca = 1'b1; e.srcb = 2'b10; end
      3:  e.iord = 1'b1;
      4:  begin e.m2r = 1'b1; e.regw = 1'b1; end
      5:  begin e.iord = 1'b1; e.memw = 1'b1; end
      6:  begin e.srca = 1'b1; e.alu = alu; end
      7:  begin e.regdst = 1'b1; e.regw = 1'b1; end
      8, 12: begin e.srca = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcen = pcen; end
      9:  begin e.srca = 1'b1; e.srcb = 2'b10; end
      10: e.regw = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // While reset is high: FETCH selects with all enables low
  function automatic exp_t resetOut();
    exp_t e;
    e = expOut(0, 3'b010, 1'b0, 1'b0);
    e.pcen = 1'b0;
    e.irw  = 1'b0;
    return e;
  endfunction

  task automatic pushExp(input string name, input exp_t e);
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input logic z);
    Op    = op;
    Funct = funct;
    Zero  = z;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Compare the current DUT outputs against the next scoreboard entry
  task automatic checkOutput();
    exp_t  e;
    exp_t  a;
    string nm;
    e  = expQ.pop_front();
    nm = nameQ.pop_front();
    a  = '{st: State, pcen: PCEn, irw: IRWrite, memw: MemWrite, regw: RegWrite,
           iord: IorD, m2r: MemtoReg, regdst: RegDst, srca: ALUSrcA,
           srcb: ALUSrcB, pcsrc: PCSrc, alu: ALUCtl, ill: Illegal};
    checks++;
    if (a === e) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
               nm, a.st, a, e.st, e);
    end
  endtask

  // Monitor: one comparison per cycle while expectations are pending
  always @(negedge clock) begin
    if (expQ.size() > 0) checkOutput();
  end

  initial begin
    reset = 1'b1;
    applyStimulus(6'b100011, 6'b000000, 1'b0);

    // Reset held for two cycles
    @(posedge clock); #1;
    pushExp("reset_c0", resetOut());
    pushExp("reset_c1", resetOut());
    runCycles(2);
    reset = 1'b0;

    // lw: 0,1,2,3,4
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    pushExp("lw_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("lw_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("lw_memadr", expOut(2, 3'b010, 1'b0, 1'b0));
    pushExp("lw_memrd",  expOut(3, 3'b010, 1'b0, 1'b0));
    pushExp("lw_memwb",  expOut(4, 3'b010, 1'b0, 1'b0));
    runCycles(5);

    // R-type slt
    applyStimulus(6'b000000, 6'b101010, 1'b0);
    pushExp("slt_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("slt_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("slt_exec",   expOut(6, 3'b111, 1'b0, 1'b0));
    pushExp("slt_aluwb",  expOut(7, 3'b010, 1'b0, 1'b0));
    runCycles(4);

    // R-type sub / and / or execute codes
    applyStimulus(6'b000000, 6'b100010, 1'b0);
    pushExp("sub_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("sub_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("sub_exec",   expOut(6, 3'b110, 1'b0, 1'b0));
    pushExp("sub_aluwb",  expOut(7, 3'b010, 1'b0, 1'b0));
    runCycles(4);
    applyStimulus(6'b000000, 6'b100100, 1'b1);
    pushExp("and_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("and_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("and_exec",   expOut(6, 3'b000, 1'b0, 1'b0));
    pushExp("and_aluwb",  expOut(7, 3'b010, 1'b0, 1'b0));
    runCycles(4);
    applyStimulus(6'b000000, 6'b100101, 1'b0);
    pushExp("or_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("or_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("or_exec",   expOut(6, 3'b001, 1'b0, 1'b0));
    pushExp("or_aluwb",  expOut(7, 3'b010, 1'b0, 1'b0));
    runCycles(4);

    // beq taken then not taken
    applyStimulus(6'b000100, 6'b000000, 1'b1);
    pushExp("beq1_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("beq1_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("beq1_branch", expOut(8, 3'b110, 1'b1, 1'b0));
    runCycles(3);
    applyStimulus(6'b000100, 6'b000000, 1'b0);
    pushExp("beq0_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("beq0_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("beq0_branch", expOut(8, 3'b110, 1'b0, 1'b0));
    runCycles(3);

    // sw
    applyStimulus(6'b101011, 6'b000000, 1'b0);
    pushExp("sw_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("sw_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("sw_memadr", expOut(2, 3'b010, 1'b0, 1'b0));
    pushExp("sw_memwr",  expOut(5, 3'b010, 1'b0, 1'b0));
    runCycles(4);

    // addi (Zero high must not matter)
    applyStimulus(6'b001000, 6'b000000, 1'b1);
    pushExp("addi_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("addi_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("addi_ex",     expOut(9, 3'b010, 1'b0, 1'b0));
    pushExp("addi_wb",     expOut(10, 3'b010, 1'b0, 1'b0));
    runCycles(4);

    // j
    applyStimulus(6'b000010, 6'b000000, 1'b0);
    pushExp("j_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("j_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("j_jump",   expOut(11, 3'b010, 1'b0, 1'b0));
    runCycles(3);

    // Illegal opcode and illegal funct
    applyStimulus(6'b111111, 6'b000000, 1'b0);
    pushExp("illop_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("illop_decode", expOut(1, 3'b010, 1'b0, 1'b1));
    runCycles(2);
    applyStimulus(6'b000000, 6'b000001, 1'b0);
    pushExp("illfn_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("illfn_decode", expOut(1, 3'b010, 1'b0, 1'b1));
    runCycles(2);

    // bne: taken branch with the feature, illegal without it
    applyStimulus(6'b000101, 6'b000000, 1'b0);
    pushExp("bne_fetch", expOut(0, 3'b010, 1'b1, 1'b0));
`ifdef MC_CTRL_BNE_EN
    pushExp("bne_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("bne_branch", expOut(12, 3'b110, 1'b1, 1'b0));
    runCycles(3);
`else
    pushExp("bne_decode", expOut(1, 3'b010, 1'b0, 1'b1));
    runCycles(2);
`endif

    // lw aborted by reset during MEMRD
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    pushExp("lwrst_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("lwrst_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    pushExp("lwrst_memadr", expOut(2, 3'b010, 1'b0, 1'b0));
    runCycles(3);
    reset = 1'b1;
    pushExp("lwrst_inreset", resetOut());
    runCycles(1);
    reset = 1'b0;
    applyStimulus(6'b001000, 6'b000000, 1'b0);
    pushExp("post_fetch",  expOut(0, 3'b010, 1'b1, 1'b0));
    pushExp("post_decode", expOut(1, 3'b010, 1'b0, 1'b0));
    runCycles(2);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (expQ.size() == 0) break;
      @(posedge clock);
    end
    if (expQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
